nes_mmc1_mapper: RTL and testbench

Parametrised NES cartridge mapper implementing MMC1 (mapper 1) banking.
- Sits between the CPU bus and PRG flash, and between the PPU pattern-fetch address and CHR storage.
- Loads bank/control registers through the MMC1 5-write serial port.
- Drives the banked flash address, CHR address, nametable mirroring and PRG-RAM enable.

---
 rtl/nes_mmc_pkg.sv | 27 ++
 rtl/nes_mmc1_mapper_serial_loader.sv | 60 ++++++
 rtl/nes_mmc1_mapper.sv | 99 +++++++++
 tb/tb_nes_mmc1_mapper.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/nes_mmc_pkg.sv
// nes_mmc_pkg: shared MMC1 encodings (mirroring, register indices, PRG modes, control reset value).
package nes_mmc_pkg;
    localparam logic [2:0] MIRROR_H   = 3'd0;
    localparam logic [2:0] MIRROR_V   = 3'd1;
    localparam logic [2:0] MIRROR_1SA = 3'd2;
    localparam logic [2:0] MIRROR_1SB = 3'd3;

    localparam logic [1:0] REG_CTRL = 2'd0;
    localparam logic [1:0] REG_CHR0 = 2'd1;
    localparam logic [1:0] REG_CHR1 = 2'd2;
    localparam logic [1:0] REG_PRG  = 2'd3;

    localparam logic [4:0] CTRL_RST = 5'h0C;

    typedef enum logic [1:0] {
        PRG_32K_A     = 2'd0,
        PRG_32K_B     = 2'd1,
        PRG_FIX_FIRST = 2'd2,
        PRG_FIX_LAST  = 2'd3
    } prg_mode_e;

    function automatic logic [2:0] mirror_of(input logic [1:0] m);
        return m == 2'd0 ? MIRROR_1SA :
               m == 2'd1 ? MIRROR_1SB :
               m == 2'd2 ? MIRROR_V   : MIRROR_H;
    endfunction
endpackage

// File: rtl/nes_mmc1_mapper_serial_loader.sv
// nes_mmc1_serial_loader: MMC1 5-write serial port.
// Ports: i_clk/i_rstn clock and async active-low reset; i_cyc_en bus cycle strobe;
// i_wr_req write to $8000-$FFFF; i_bit7/i_bit0 write data bits; i_sel target register index;
// o_load one-cycle load pulse; o_ctrl_rst reset-bit write; o_data 5-bit value; o_sel register index.
// Optional: NES_MMC1_CONSEC_WR_FILTER_EN drops an accepted write directly following another.
module nes_mmc1_serial_loader
    import nes_mmc_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rstn,
    input  logic       i_cyc_en,
    input  logic       i_wr_req,
    input  logic       i_bit7,
    input  logic       i_bit0,
    input  logic [1:0] i_sel,
    output logic       o_load,
    output logic       o_ctrl_rst,
    output logic [4:0] o_data,
    output logic [1:0] o_sel
);
    logic [4:0] sr_q, sr_d;
    logic [2:0] cnt_q, cnt_d;
    logic       acc, wr;

    assign acc = i_cyc_en & i_wr_req;

`ifdef NES_MMC1_CONSEC_WR_FILTER_EN
    // Remembers whether the last bus cycle was an accepted write, so the second
    // write of a read-modify-write pair is dropped.
    logic flag_q, flag_d;
    assign wr     = acc & ~flag_q;
    assign flag_d = i_cyc_en ? acc : flag_q;
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) flag_q <= 1'b0;
        else         flag_q <= flag_d;
    end
`else
    assign wr = acc;
`endif

    assign o_ctrl_rst = wr & i_bit7;
    assign o_load     = wr & ~i_bit7 & (cnt_q == 3'd4);
    assign o_data     = {i_bit0, sr_q[4:1]};
    assign o_sel      = i_sel;

    always_comb begin
        sr_d  = (o_ctrl_rst | o_load) ? 5'd0 : wr ? o_data : sr_q;
        cnt_d = (o_ctrl_rst | o_load) ? 3'd0 : wr ? cnt_q + 3'd1 : cnt_q;
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            sr_q  <= 5'd0;
            cnt_q <= 3'd0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/nes_mmc1_mapper.sv
// nes_mmc1_mapper: MMC1 (mapper 1) PRG/CHR banking, mirroring and PRG-RAM enable.
// Ports: i_clk/i_rstn clock and async active-low reset; i_bus_* CPU bus; o_mmc_rdata PRG read data;
// o_fl_addr/i_fl_rdata PRG flash; i_ppu_addr/o_chr_addr CHR banking; o_sram_addr_ext RAM page (0);
// o_prg_ram_en $6000-$7FFF enable; o_mirror_mode nametable mirroring; o_irq_n (always 1).
// Optional: NES_MMC1_CONSEC_WR_FILTER_EN (see nes_mmc1_serial_loader).
module nes_mmc1_mapper
    import nes_mmc_pkg::*;
#(
    parameter int unsigned PRG_BANK_W    = 4,
    parameter int unsigned PRG_LAST_BANK = 15,
    parameter int unsigned CHR_BANK_W    = 5,
    parameter logic [22:0] FL_PRG_BASE   = 23'h000000
) (
    input  logic                   i_clk,
    input  logic                   i_rstn,
    input  logic [15:0]            i_bus_addr,
    input  logic [7:0]             i_bus_wdata,
    input  logic                   i_bus_r_wn,
    input  logic                   i_bus_cyc_en,
    output logic [7:0]             o_mmc_rdata,
    output logic [22:0]            o_fl_addr,
    input  logic [7:0]             i_fl_rdata,
    input  logic [12:0]            i_ppu_addr,
    output logic [CHR_BANK_W+11:0] o_chr_addr,
    output logic [7:0]             o_sram_addr_ext,
    output logic                   o_prg_ram_en,
    output logic [2:0]             o_mirror_mode,
    output logic                   o_irq_n
);
    logic [4:0]            ctrl_q, ctrl_d, chr0_q, chr0_d, chr1_q, chr1_d, prg_q, prg_d;
    logic                  ld, ctrl_rst;
    logic [4:0]            ld_data;
    logic [1:0]            ld_sel;
    logic                  a14, ppu12;
    logic [1:0]            prg_mode;
    logic [PRG_BANK_W-1:0] prg_sel, prg_bank;
    logic [CHR_BANK_W-1:0] chr_bank;
    logic                  unused_wdata;

    assign unused_wdata = ^i_bus_wdata[6:1];

    nes_mmc1_serial_loader u_loader (
        .i_clk      (i_clk),
        .i_rstn     (i_rstn),
        .i_cyc_en   (i_bus_cyc_en),
        .i_wr_req   (~i_bus_r_wn & i_bus_addr[15]),
        .i_bit7     (i_bus_wdata[7]),
        .i_bit0     (i_bus_wdata[0]),
        .i_sel      (i_bus_addr[14:13]),
        .o_load     (ld),
        .o_ctrl_rst (ctrl_rst),
        .o_data     (ld_data),
        .o_sel      (ld_sel)
    );

    always_comb begin
        // A reset-bit write forces PRG mode 3 and keeps the other control bits.
        ctrl_d = ctrl_rst ? {ctrl_q[4], 2'b11, ctrl_q[1:0]} :
                 (ld && ld_sel == REG_CTRL) ? ld_data : ctrl_q;
        chr0_d = (ld && ld_sel == REG_CHR0) ? ld_data : chr0_q;
        chr1_d = (ld && ld_sel == REG_CHR1) ? ld_data : chr1_q;
        prg_d  = (ld && ld_sel == REG_PRG)  ? ld_data : prg_q;
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            ctrl_q <= CTRL_RST;
            chr0_q <= 5'd0;
            chr1_q <= 5'd0;
            prg_q  <= 5'd0;
        end else begin
            ctrl_q <= ctrl_d;
            chr0_q <= chr0_d;
            chr1_q <= chr1_d;
            prg_q  <= prg_d;
        end
    end

    assign a14      = i_bus_addr[14];
    assign ppu12    = i_ppu_addr[12];
    assign prg_mode = ctrl_q[3:2];
    assign prg_sel  = prg_q[PRG_BANK_W-1:0];

    always_comb begin
        prg_bank = (prg_mode == PRG_FIX_LAST)  ? (a14 ? PRG_BANK_W'(PRG_LAST_BANK) : prg_sel) :
                   (prg_mode == PRG_FIX_FIRST) ? (a14 ? prg_sel : '0) :
                   {prg_sel[PRG_BANK_W-1:1], a14};
        chr_bank = ctrl_q[4] ? (ppu12 ? chr1_q[CHR_BANK_W-1:0] : chr0_q[CHR_BANK_W-1:0]) :
                   {chr0_q[CHR_BANK_W-1:1], ppu12};
    end

    assign o_fl_addr       = i_bus_addr[15] ? FL_PRG_BASE + 23'({prg_bank, i_bus_addr[13:0]}) : 23'd0;
    assign o_mmc_rdata     = i_bus_addr[15] ? i_fl_rdata : 8'h00;
    assign o_chr_addr      = {chr_bank, i_ppu_addr[11:0]};
    assign o_mirror_mode   = mirror_of(ctrl_q[1:0]);
    assign o_prg_ram_en    = ~prg_q[4];
    assign o_sram_addr_ext = 8'h00;
    assign o_irq_n         = 1'b1;
endmodule

// File: tb/tb_nes_mmc1_mapper.sv
// tb_nes_mmc1_mapper: randomized scoreboard bench for nes_mmc1_mapper against a behavioural model.
module tb_nes_mmc1_mapper;
    logic        clk = 1'b0, rstn = 1'b0;
    logic [15:0] bus_addr = 16'h0;
    logic [7:0]  bus_wdata = 8'h0, fl_rdata = 8'h0;
    logic        r_wn = 1'b1, cyc_en = 1'b0;
    logic [12:0] ppu_addr = 13'h0;
    logic [7:0]  mmc_rdata, sram_ext;
    logic [22:0] fl_addr;
    logic [16:0] chr_addr;
    logic        prg_ram_en, irq_n;
    logic [2:0]  mirror;

    nes_mmc1_mapper dut (
        .i_clk           (clk),
        .i_rstn          (rstn),
        .i_bus_addr      (bus_addr),
        .i_bus_wdata     (bus_wdata),
        .i_bus_r_wn      (r_wn),
        .i_bus_cyc_en    (cyc_en),
        .o_mmc_rdata     (mmc_rdata),
        .o_fl_addr       (fl_addr),
        .i_fl_rdata      (fl_rdata),
        .i_ppu_addr      (ppu_addr),
        .o_chr_addr      (chr_addr),
        .o_sram_addr_ext (sram_ext),
        .o_prg_ram_en    (prg_ram_en),
        .o_mirror_mode   (mirror),
        .o_irq_n         (irq_n)
    );

    always #5 clk = ~clk;

    typedef struct {
        int fl;
        int chr;
        int mir;
        int ram;
        int rd;
    } exp_t;

    exp_t q[$];
    int   m_ctrl, m_chr0, m_chr1, m_prg;
    bit   m_bits[$];
    bit   m_flag;
    int   n_vec = 0, n_err = 0;
    int   mir_map[4] = '{2, 3, 1, 0};

    task automatic m_reset();
        m_ctrl = 12; m_chr0 = 0; m_chr1 = 0; m_prg = 0;
        m_bits.delete();
        m_flag = 0;
    endtask

    function automatic exp_t predict();
        exp_t e;
        int a = int'(bus_addr);
        int hi14 = (a / 16384) % 2;
        int mode = (m_ctrl / 4) % 4;
        int p = m_prg % 16;
        int bank, pa, hi12, cb;
        if (mode < 2)       bank = (p / 2) * 2 + hi14;
        else if (mode == 2) bank = hi14 ? p : 0;
        else                bank = hi14 ? 15 : p;
        e.fl = (a >= 32768) ? bank * 16384 + a % 16384 : 0;
        pa = int'(ppu_addr);
        hi12 = pa / 4096;
        cb = (m_ctrl >= 16) ? (hi12 ? m_chr1 : m_chr0) : (m_chr0 / 2) * 2 + hi12;
        e.chr = cb * 4096 + pa % 4096;
        e.mir = mir_map[m_ctrl % 4];
        e.ram = (m_prg < 16) ? 1 : 0;
        e.rd  = (a >= 32768) ? int'(fl_rdata) : 0;
        return e;
    endfunction

    // Applies the write (if any) that the next rising edge will see.
    task automatic m_step();
        bit acc, eff;
        int v, tgt;
        acc = cyc_en && !r_wn && bus_addr >= 16'h8000;
        eff = acc;
`ifdef NES_MMC1_CONSEC_WR_FILTER_EN
        eff = acc && !m_flag;
        if (cyc_en) m_flag = acc;
`endif
        if (!eff) return;
        if (bus_wdata >= 8'h80) begin
            m_bits.delete();
            m_ctrl = (m_ctrl / 16) * 16 + 12 + m_ctrl % 4;
            return;
        end
        m_bits.push_back(bus_wdata[0]);
        if (m_bits.size() < 5) return;
        v = 0;
        for (int i = 0; i < 5; i++) v += int'(m_bits[i]) << i;
        m_bits.delete();
        tgt = (int'(bus_addr) / 8192) % 4;
        if (tgt == 0)      m_ctrl = v;
        else if (tgt == 1) m_chr0 = v;
        else if (tgt == 2) m_chr1 = v;
        else               m_prg  = v;
    endtask

    task automatic drive(input logic [15:0] a, input logic [7:0] d, input logic rw,
                         input logic en, input logic rn, input int ppu);
        @(posedge clk);
        #1;
        bus_addr = a; bus_wdata = d; r_wn = rw; cyc_en = en; rstn = rn;
        ppu_addr = (ppu < 0) ? 13'($urandom) : 13'(ppu);
        fl_rdata = 8'($urandom);
        if (!rn) m_reset();
        q.push_back(predict());
        if (rn) m_step();
    endtask

    task automatic rd(input logic [15:0] a, input int ppu);
        drive(a, 8'($urandom), 1'b1, 1'b1, 1'b1, ppu);
    endtask

    task automatic shift_wr(input logic [15:0] a, input logic b);
        drive(a, {7'd0, b}, 1'b0, 1'b1, 1'b1, -1);
        rd(16'h8000 | 16'($urandom), -1);
    endtask

    task automatic ser(input logic [15:0] a, input logic [4:0] v);
        for (int i = 0; i < 5; i++) shift_wr(a, v[i]);
    endtask

    task automatic chk(input string name, input int act, input int req);
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                e = q.pop_front();
                n_vec++;
                chk("fl_addr", int'(fl_addr), e.fl);
                chk("chr_addr", int'(chr_addr), e.chr);
                chk("mirror", int'(mirror), e.mir);
                chk("prg_ram_en", int'(prg_ram_en), e.ram);
                chk("rdata", int'(mmc_rdata), e.rd);
                chk("irq_n", int'(irq_n), 1);
                chk("sram_ext", int'(sram_ext), 0);
            end
        end
    end

    initial begin
        int k;
        m_reset();
        for (int i = 0; i < 3; i++) drive(16'hC123, 8'h00, 1'b1, 1'b0, 1'b0, -1);
        rd(16'hC123, -1);
        rd(16'h8000, -1);
        ser(16'hE000, 5'h03);
        rd(16'h8010, -1);
        rd(16'hC000, -1);
        ser(16'h8000, 5'h12);
        ser(16'hC000, 5'h05);
        rd(16'h8000, 'h1123);
        rd(16'h8000, 'h0123);
        for (int i = 0; i < 3; i++) shift_wr(16'hE000, 1'b1);
        drive(16'hE000, 8'h80, 1'b0, 1'b1, 1'b1, -1);
        rd(16'hC000, -1);
        ser(16'hE000, 5'h01);
        rd(16'h8000, -1);
        rd(16'hC000, -1);
        drive(16'h6000, 8'h80, 1'b0, 1'b1, 1'b1, -1);
        drive(16'h9000, 8'h80, 1'b1, 1'b1, 1'b1, -1);
        ser(16'hE000, 5'h10);
        rd(16'h8000, -1);
        shift_wr(16'hE000, 1'b1);
        shift_wr(16'hE000, 1'b1);
        drive(16'hC123, 8'h00, 1'b1, 1'b1, 1'b0, -1);
        drive(16'hC123, 8'h00, 1'b1, 1'b1, 1'b0, -1);
        rd(16'hC123, -1);
        ser(16'hA000, 5'h1F);
        rd(16'h8000, 'h1FFF);
        drive(16'hE000, 8'h01, 1'b0, 1'b1, 1'b1, -1);
        drive(16'hE000, 8'h01, 1'b0, 1'b1, 1'b1, -1);
        rd(16'h8000, -1);
        for (int i = 0; i < 2500; i++) begin
            k = int'($urandom_range(0, 999));
            drive(16'h8000 | 16'($urandom) & ~16'(($urandom_range(0, 7) == 0) ? 16'h8000 : 16'h0),
                  ($urandom_range(0, 15) == 0) ? 8'h80 : 8'($urandom) & 8'h7F,
                  1'($urandom), ($urandom_range(0, 3) != 0), (k > 2), -1);
        end
        rd(16'hC000, -1);
        repeat (3) @(posedge clk);
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending, required 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
